bday_seq_tx: RTL and testbench
==============================

Name: bday_seq_tx

Overview:
- Serial pattern transmitter that drives the Happy Birthday detector's receiver input.
- Sends the 14-character ASCII message "HAPPY BIRTHDAY" (112 bits, MSB-first per character) one bit per clock.
- Inserts pseudo-random LFSR filler bits between messages and exports a running bit index for the receiver.
- Tracks the number of complete messages sent, so the bench can compare it against the receiver hit count.

Parameters:
- GAP_BITS, 16, number of LFSR filler bits sent before each message; legal range 1..255.
- NUM_MSGS, 4, messages per burst; 0 means send until disabled.
- LFSR_SEED, 8'hA5, LFSR value loaded on reset; must be non-zero.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous active-low reset.
- i_tx_en_n  input  1  active-low transmit enable.
- o_bit_seq  output  1  serial bit stream to the receiver.
- o_bit_valid  output  1  high when o_bit_seq carries a gap or message bit.
- o_count_for_rx  output  10  running bit index within the current burst.
- o_msg_done  output  1  one-cycle pulse on the cycle carrying the last message bit.
- o_msg_count  output  6  number of complete messages sent; saturates at 63.
- o_busy  output  1  high in the GAP and MSG states.

Behaviour:
- Reset (i_rst low, asynchronous) forces:
  - state IDLE;
  - all outputs 0;
  - LFSR loaded with LFSR_SEED;
  - internal gap, bit and message counters at 0.
- All outputs are registered. FSM states: IDLE, GAP, MSG, DONE.
- IDLE:
  - o_bit_valid=0, o_bit_seq=0.
  - When i_tx_en_n is sampled low: go to GAP next cycle, clear o_count_for_rx and o_msg_count.
- GAP:
  - Outputs one filler bit per cycle for GAP_BITS cycles.
  - o_bit_seq = LFSR[0]; the LFSR advances each GAP cycle.
  - LFSR polynomial x^8+x^6+x^5+x^4+1, Fibonacci form, shifting right.
  - After the last gap bit, go to MSG.
  - If i_tx_en_n is sampled high during GAP, go to IDLE on the next cycle. The current bit is still valid.
- MSG:
  - Outputs 112 bits, character index 0..13, bit 7 down to bit 0.
  - ROM contents: 48 41 50 50 59 20 42 49 52 54 48 44 41 59 (hex). The first message bit is 0.
  - i_tx_en_n is ignored in MSG; a message is never truncated.
  - On bit 111, assert o_msg_done for that cycle.
  - o_msg_count increments by 1 the following cycle, saturating at 63.
  - Next state:
    - NUM_MSGS≠0 and messages sent == NUM_MSGS: go to DONE.
    - Else if i_tx_en_n is high: go to IDLE.
    - Else: go to GAP.
- DONE:
  - o_bit_valid=0, o_busy=0; o_msg_count holds its value.
  - Returns to IDLE only after i_tx_en_n is sampled high. A burst requires the enable to be released and reasserted.
- o_count_for_rx:
  - Increments on every cycle with o_bit_valid=1, wrapping 1023→0.
  - Holds its value in IDLE and DONE until the next burst starts.
- The LFSR is not reseeded between bursts; only reset reloads it.
- Reset asserted mid-message: everything returns to reset values immediately, and no o_msg_done is produced.
- Enable edge in the same cycle as the last gap bit: MSG is still entered.

Optional Feature:
- Macro: BDAY_CORRUPT_INJ_EN.
- Defined:
  - Every 4th message (message numbers 4, 8, 12… within a burst) has bit index 40 inverted.
  - Adds output o_corrupt_count (6 bits, saturating at 63, reset 0, cleared at burst start).
  - o_corrupt_count increments alongside o_msg_count for corrupted messages.
  - o_msg_count still counts all messages.
- Undefined:
  - No corruption logic and no o_corrupt_count port.
  - Every message is bit-exact.

Test Plan:
1. Release reset and hold i_tx_en_n high for 50 cycles -> o_bit_valid=0, o_busy=0, all outputs 0.
2. Defaults; drive i_tx_en_n low and hold -> 16 gap bits, then 112 message bits matching the ROM (first 8 message bits 0,1,0,0,1,0,0,0). o_msg_done pulses 4 times; o_msg_count=4; state DONE; o_count_for_rx=512.
3. NUM_MSGS=0, enable low for 3 messages, raise i_tx_en_n at message bit 50 -> message completes; o_msg_count=3; IDLE the cycle after bit 111.
4. Raise i_tx_en_n at gap bit 5 of the first gap -> IDLE next cycle; o_msg_count=0; o_count_for_rx=6.
5. Assert i_rst at message bit 60 -> all outputs 0 asynchronously. Re-enable -> the gap bit sequence equals the post-reset sequence from scenario 2.
6. Connect to the receiver, NUM_MSGS=8, with BDAY_CORRUPT_INJ_EN defined -> o_msg_count=8, o_corrupt_count=2, receiver hit count 6. Without the macro, receiver hit count 8.

Source files
------------

// File: rtl/bday_seq_tx.sv
// Serial "HAPPY BIRTHDAY" transmitter: LFSR filler gap, then a 112-bit message, repeated per burst.
// Optional build macro BDAY_CORRUPT_INJ_EN inverts bit 40 of every 4th message and adds o_corrupt_count.
module bday_seq_tx #(
  parameter int unsigned GAP_BITS  = 16,
  parameter int unsigned NUM_MSGS  = 4,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_en_n,
  output logic       o_bit_seq,
  output logic       o_bit_valid,
  output logic [9:0] o_count_for_rx,
  output logic       o_msg_done,
  output logic [5:0] o_msg_count,
`ifdef BDAY_CORRUPT_INJ_EN
  output logic [5:0] o_corrupt_count,
`endif
  output logic       o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_MSG  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [6:0]  LAST_BIT    = 7'd111;
  localparam logic [6:0]  CORRUPT_BIT = 7'd40;
  localparam logic [7:0]  GAP_LAST    = 8'(GAP_BITS);
  localparam logic [15:0] MSG_LIMIT   = 16'(NUM_MSGS);

  function automatic logic [7:0] rom_char(input logic [3:0] idx);
    logic [7:0] ch;
    case (idx)
      4'd0:    ch = 8'h48;
      4'd1:    ch = 8'h41;
      4'd2:    ch = 8'h50;
      4'd3:    ch = 8'h50;
      4'd4:    ch = 8'h59;
      4'd5:    ch = 8'h20;
      4'd6:    ch = 8'h42;
      4'd7:    ch = 8'h49;
      4'd8:    ch = 8'h52;
      4'd9:    ch = 8'h54;
      4'd10:   ch = 8'h48;
      4'd11:   ch = 8'h44;
      4'd12:   ch = 8'h41;
      4'd13:   ch = 8'h59;
      default: ch = 8'h00;
    endcase
    return ch;
  endfunction

  // Characters go out MSB first, so bit index 0 of a character is its bit 7.
  function automatic logic msg_bit(input logic [6:0] idx);
    logic [7:0] ch;
    ch = rom_char(idx[6:3]);
    return ch[3'd7 - idx[2:0]];
  endfunction

  // x^8+x^6+x^5+x^4+1, Fibonacci, shifting right; feedback enters at bit 7.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[4], l[7:1]};
  endfunction

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [6:0]  bit_idx_q, bit_idx_d;
  logic [15:0] msg_num_q, msg_num_d;
  logic        bit_seq_q, bit_seq_d;
  logic        bit_valid_q, bit_valid_d;
  logic [9:0]  count_q, count_d;
  logic        msg_done_q, msg_done_d;
  logic [5:0]  msg_count_q, msg_count_d;
  logic        busy_q, busy_d;
  logic        emit_gap, emit_msg;
  logic        corrupt_msg;
`ifdef BDAY_CORRUPT_INJ_EN
  logic [5:0]  corrupt_q, corrupt_d;
`endif

  // Message number (msg_num_q + 1) is a multiple of four exactly when the low bits are 3.
`ifdef BDAY_CORRUPT_INJ_EN
  assign corrupt_msg = (msg_num_q[1:0] == 2'b11);
`else
  assign corrupt_msg = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    gap_cnt_d   = gap_cnt_q;
    bit_idx_d   = bit_idx_q;
    msg_num_d   = msg_num_q;
    bit_seq_d   = 1'b0;
    bit_valid_d = 1'b0;
    msg_done_d  = 1'b0;
    busy_d      = 1'b0;
    msg_count_d = msg_count_q;
    count_d     = count_q + {9'd0, bit_valid_q};
    emit_gap    = 1'b0;
    emit_msg    = 1'b0;
`ifdef BDAY_CORRUPT_INJ_EN
    corrupt_d   = corrupt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!i_tx_en_n) begin
          state_d     = S_GAP;
          count_d     = '0;
          msg_count_d = '0;
          msg_num_d   = '0;
          gap_cnt_d   = 8'd1;
          emit_gap    = 1'b1;
`ifdef BDAY_CORRUPT_INJ_EN
          corrupt_d   = '0;
`endif
        end
      end

      S_GAP: begin
        // The last gap bit always leads into the message, even if enable drops.
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = S_MSG;
          bit_idx_d = '0;
          emit_msg  = 1'b1;
        end else if (i_tx_en_n) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
          emit_gap  = 1'b1;
        end
      end

      S_MSG: begin
        if (bit_idx_q != LAST_BIT) begin
          bit_idx_d = bit_idx_q + 7'd1;
          emit_msg  = 1'b1;
        end else begin
          msg_num_d   = msg_num_q + 16'd1;
          msg_count_d = sat_inc(msg_count_q);
`ifdef BDAY_CORRUPT_INJ_EN
          if (corrupt_msg) corrupt_d = sat_inc(corrupt_q);
`endif
          if ((MSG_LIMIT != 16'd0) && (msg_num_d == MSG_LIMIT)) begin
            state_d = S_DONE;
          end else if (i_tx_en_n) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = 8'd1;
            emit_gap  = 1'b1;
          end
        end
      end

      S_DONE: begin
        if (i_tx_en_n) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (emit_gap) begin
      bit_seq_d   = lfsr_q[0];
      lfsr_d      = lfsr_step(lfsr_q);
      bit_valid_d = 1'b1;
      busy_d      = 1'b1;
    end

    if (emit_msg) begin
      bit_seq_d   = msg_bit(bit_idx_d) ^ (corrupt_msg && (bit_idx_d == CORRUPT_BIT));
      bit_valid_d = 1'b1;
      busy_d      = 1'b1;
      msg_done_d  = (bit_idx_d == LAST_BIT);
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      gap_cnt_q   <= '0;
      bit_idx_q   <= '0;
      msg_num_q   <= '0;
      bit_seq_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      count_q     <= '0;
      msg_done_q  <= 1'b0;
      msg_count_q <= '0;
      busy_q      <= 1'b0;
`ifdef BDAY_CORRUPT_INJ_EN
      corrupt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      gap_cnt_q   <= gap_cnt_d;
      bit_idx_q   <= bit_idx_d;
      msg_num_q   <= msg_num_d;
      bit_seq_q   <= bit_seq_d;
      bit_valid_q <= bit_valid_d;
      count_q     <= count_d;
      msg_done_q  <= msg_done_d;
      msg_count_q <= msg_count_d;
      busy_q      <= busy_d;
`ifdef BDAY_CORRUPT_INJ_EN
      corrupt_q   <= corrupt_d;
`endif
    end
  end

  assign o_bit_seq      = bit_seq_q;
  assign o_bit_valid    = bit_valid_q;
  assign o_count_for_rx = count_q;
  assign o_msg_done     = msg_done_q;
  assign o_msg_count    = msg_count_q;
  assign o_busy         = busy_q;
`ifdef BDAY_CORRUPT_INJ_EN
  assign o_corrupt_count = corrupt_q;
`endif

endmodule

// File: tb/tb_bday_seq_tx.sv
// Bench for bday_seq_tx: vector table and corner sequences on two parameterisations,
// with every cycle compared against a position-based reference model of the stream.
module tb_bday_seq_tx;

`ifdef BDAY_CORRUPT_INJ_EN
  localparam bit CORRUPT = 1'b1;
`else
  localparam bit CORRUPT = 1'b0;
`endif
  localparam int GAP_A = 16;
  localparam int NUM_A = 4;
  localparam int GAP_B = 1;
  localparam int NUM_B = 0;

  logic clk, rst_n, en_a, en_b;
  logic seq_a, valid_a, done_a, busy_a;
  logic seq_b, valid_b, done_b, busy_b;
  logic [9:0] cnt_a, cnt_b;
  logic [5:0] mc_a, mc_b;
`ifdef BDAY_CORRUPT_INJ_EN
  logic [5:0] corr_a, corr_b;
`endif

  int total = 0;
  int bad   = 0;

  bday_seq_tx u_dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_tx_en_n(en_a),
    .o_bit_seq(seq_a), .o_bit_valid(valid_a), .o_count_for_rx(cnt_a),
    .o_msg_done(done_a), .o_msg_count(mc_a),
`ifdef BDAY_CORRUPT_INJ_EN
    .o_corrupt_count(corr_a),
`endif
    .o_busy(busy_a)
  );

  bday_seq_tx #(.GAP_BITS(GAP_B), .NUM_MSGS(NUM_B), .LFSR_SEED(8'h3C)) u_dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_tx_en_n(en_b),
    .o_bit_seq(seq_b), .o_bit_valid(valid_b), .o_count_for_rx(cnt_b),
    .o_msg_done(done_b), .o_msg_count(mc_b),
`ifdef BDAY_CORRUPT_INJ_EN
    .o_corrupt_count(corr_b),
`endif
    .o_busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: a burst is a repeating frame of gap+112 positions.
  typedef struct {
    bit       active;
    bit       done;
    int       pos;
    int       count;
    int       msgs;
    int       corr;
    bit [7:0] lfsr;
    bit       gbit;
  } mdl_t;

  function automatic bit msg_ref_bit(int idx);
    string s;
    byte   c;
    s = "HAPPY BIRTHDAY";
    c = s[idx / 8];
    return c[7 - (idx % 8)];
  endfunction

  function automatic mdl_t mdl_reset(bit [7:0] seed);
    mdl_t m;
    m = '{default: 0};
    m.lfsr = seed;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m_in, logic en_n, int gap, int num);
    mdl_t m;
    m = m_in;
    if (m.done) begin
      if (en_n) m.done = 0;
    end else if (!m.active) begin
      if (!en_n) begin
        m.active = 1; m.pos = 0; m.count = 0; m.msgs = 0; m.corr = 0;
      end
    end else begin
      m.count = (m.count + 1) % 1024;
      if (m.pos == gap + 111) begin
        if (CORRUPT && (m.msgs % 4 == 3)) m.corr++;
        m.msgs++;
        if (num != 0 && m.msgs == num) begin
          m.active = 0; m.done = 1;
        end else if (en_n) m.active = 0;
        else m.pos = 0;
      end else if (m.pos < gap - 1 && en_n) m.active = 0;
      else m.pos++;
    end
    // Each active step lands on a fresh position; gap positions draw one LFSR bit.
    if (m.active && m.pos < gap) begin
      m.gbit = m.lfsr[0];
      m.lfsr = {^(m.lfsr & 8'b0001_1101), m.lfsr[7:1]};
    end
    return m;
  endfunction

  task automatic cmp(input string t, input mdl_t m, input int gap, input logic seq,
                     input logic valid, input logic done, input logic busy,
                     input logic [9:0] cnt, input logic [5:0] mc);
    bit eb;
    int idx;
    eb = 0;
    if (m.active) begin
      if (m.pos < gap) eb = m.gbit;
      else begin
        idx = m.pos - gap;
        eb  = msg_ref_bit(idx);
        if (CORRUPT && idx == 40 && (m.msgs % 4 == 3)) eb = !eb;
      end
    end
    check({t, "_seq"},   seq,   eb);
    check({t, "_valid"}, valid, m.active);
    check({t, "_busy"},  busy,  m.active);
    check({t, "_done"},  done,  m.active && (m.pos == gap + 111));
    check({t, "_cnt"},   cnt,   m.count);
    check({t, "_mc"},    mc,    (m.msgs > 63) ? 63 : m.msgs);
  endtask

  mdl_t ma, mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= mdl_reset(8'hA5);
      mb <= mdl_reset(8'h3C);
    end else begin
      ma <= mdl_step(ma, en_a, GAP_A, NUM_A);
      mb <= mdl_step(mb, en_b, GAP_B, NUM_B);
    end
  end

  always @(negedge clk) begin
    cmp("mdl_a", ma, GAP_A, seq_a, valid_a, done_a, busy_a, cnt_a, mc_a);
    cmp("mdl_b", mb, GAP_B, seq_b, valid_b, done_b, busy_b, cnt_b, mc_b);
`ifdef BDAY_CORRUPT_INJ_EN
    check("mdl_a_corr", corr_a, (ma.corr > 63) ? 63 : ma.corr);
    check("mdl_b_corr", corr_b, (mb.corr > 63) ? 63 : mb.corr);
`endif
  end

  // Stream capture and done-pulse count for instance A.
  bit stream_a[$];
  int done_cnt_a = 0;
  always @(negedge clk) begin
    if (valid_a === 1'b1) stream_a.push_back(seq_a);
    if (done_a === 1'b1) done_cnt_a++;
  end

  typedef struct {
    logic en_n;
    int   hold;
    logic exp_valid;
    logic exp_busy;
    int   exp_count;
    int   exp_msgs;
  } vec_t;

  vec_t vecs[7];
  bit   gap_ref[16];
  bit   first_msg[8];
  bit   seed_bits[8];
  bit   found;

  initial begin
    rst_n = 1'b0;
    en_a  = 1'b1;
    en_b  = 1'b1;

    vecs[0] = '{1'b1, 50,  1'b0, 1'b0, 0,   0};  // idle after reset
    vecs[1] = '{1'b0, 520, 1'b0, 1'b0, 512, 4};  // full burst ends in DONE
    vecs[2] = '{1'b0, 5,   1'b0, 1'b0, 512, 4};  // DONE holds while enabled
    vecs[3] = '{1'b1, 1,   1'b0, 1'b0, 512, 4};  // release -> IDLE, values held
    vecs[4] = '{1'b0, 6,   1'b1, 1'b1, 5,   0};  // new burst, showing gap bit 5
    vecs[5] = '{1'b1, 1,   1'b0, 1'b0, 6,   0};  // abort in gap
    vecs[6] = '{1'b1, 5,   1'b0, 1'b0, 6,   0};

    first_msg = '{0, 1, 0, 0, 1, 0, 0, 0};
    seed_bits = '{1, 0, 1, 0, 0, 1, 0, 1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      en_a = vecs[i].en_n;
      repeat (vecs[i].hold) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), valid_a, vecs[i].exp_valid);
      check($sformatf("vec%0d_busy", i),  busy_a,  vecs[i].exp_busy);
      check($sformatf("vec%0d_cnt", i),   cnt_a,   vecs[i].exp_count);
      check($sformatf("vec%0d_mc", i),    mc_a,    vecs[i].exp_msgs);
`ifdef BDAY_CORRUPT_INJ_EN
      if (i == 1) check("vec1_corr", corr_a, 1);
`endif
    end

    check("burst_done_pulses", done_cnt_a, 4);
    check("stream_len", stream_a.size(), 518);
    if (stream_a.size() >= 24) begin
      for (int i = 0; i < 8; i++) check($sformatf("seed_bit%0d", i), stream_a[i], seed_bits[i]);
      for (int i = 0; i < 8; i++) check($sformatf("msg_bit%0d", i), stream_a[16 + i], first_msg[i]);
      for (int i = 0; i < 16; i++) gap_ref[i] = stream_a[i];
    end

    // Asynchronous reset in the middle of message bit 60.
    en_a = 1'b0;
    repeat (1 + GAP_A + 60) @(posedge clk);
    #1;
    check("t5_pre_valid", valid_a, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_seq",   seq_a,   0);
    check("t5_rst_valid", valid_a, 0);
    check("t5_rst_done",  done_a,  0);
    check("t5_rst_busy",  busy_a,  0);
    check("t5_rst_cnt",   cnt_a,   0);
    check("t5_rst_mc",    mc_a,    0);
    @(negedge clk);
    stream_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t5_stream_len_ok", stream_a.size() >= 16, 1);
    if (stream_a.size() >= 16)
      for (int i = 0; i < 16; i++) check($sformatf("t5_gap%0d", i), stream_a[i], gap_ref[i]);
    en_a = 1'b1;

    // Instance B (gap 1, unlimited): enable dropped in the middle of message 3.
    en_b = 1'b0;
    repeat (1 + 2 * (GAP_B + 112) + GAP_B + 50) @(posedge clk);
    @(negedge clk);
    check("t3_mid_valid", valid_b, 1);
    check("t3_mid_mc", mc_b, 2);
    en_b = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (done_b === 1'b1) found = 1'b1;
    end
    check("t3_done_seen", found, 1);
    @(negedge clk);
    check("t3_idle_valid", valid_b, 0);
    check("t3_idle_busy",  busy_b,  0);
    check("t3_idle_mc",    mc_b,    3);
    check("t3_idle_cnt",   cnt_b,   3 * (GAP_B + 112));

    // Long run: message count saturation and bit index wrap.
    en_b = 1'b0;
    repeat (64 * (GAP_B + 112) + 10) @(posedge clk);
    @(negedge clk);
    check("sat_mc",  mc_b,  63);
    check("wrap_cnt", cnt_b, (64 * (GAP_B + 112) + 9) % 1024);
    en_b = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) en_b = ~en_b;
      if ($urandom_range(0, 59) == 0) en_a = ~en_a;
    end
    en_a = 1'b1;
    en_b = 1'b1;
    repeat (300) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
